// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: SP select codes shared with the SP unit and the sequencer state encoding
package stack_seq_pkg;
  localparam logic [2:0] SP_SEL_HOLD = 3'd0;
  localparam logic [2:0] SP_SEL_INCR = 3'd1;
  localparam logic [2:0] SP_SEL_DECR = 3'd2;
  localparam logic [2:0] SP_SEL_TEMP = 3'd3;
  localparam logic [2:0] SP_SEL_REL  = 3'd4;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_HI = 3'd1,
    PUSH_LO = 3'd2,
    POP_LO  = 3'd3,
    POP_HI  = 3'd4
  } state_t;
endpackage

// File: rtl/stack_seq.sv
// stack_seq: splits 16-bit PUSH/POP into two byte transactions, steering the SP unit around each byte
module stack_seq
  import stack_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_push,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        cmd_done,
  output logic [15:0] pop_data,
  input  logic [15:0] sp,
  output logic [2:0]  sp_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);
  state_t      r_state;
  logic [15:0] r_payload;
  logic [7:0]  r_lo;
  logic        r_done;
  logic [15:0] r_pop_data;
  logic        w_accept;
  logic        w_pop;
  assign cmd_ready = r_state == IDLE;
  assign cmd_done  = r_done;
  assign pop_data  = r_pop_data;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_pop     = r_state == POP_LO || r_state == POP_HI;
  assign mem_req   = r_state != IDLE;
  assign mem_we    = r_state == PUSH_HI || r_state == PUSH_LO;
  assign mem_addr  = mem_req ? sp : 16'h0000;
  assign mem_wdata = r_state == PUSH_HI ? r_payload[15:8] :
                     r_state == PUSH_LO ? r_payload[7:0] : 8'h00;
  // SP moves before each push byte and after each pop byte, so every state sees the adjusted SP
  always_comb begin
    sp_sel = SP_SEL_HOLD;
    if (!reset)
      sp_sel = (w_accept && cmd_push) || (r_state == PUSH_HI && mem_ack) ? SP_SEL_DECR :
               w_pop && mem_ack ? SP_SEL_INCR : SP_SEL_HOLD;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_payload  <= 16'h0000;
      r_lo       <= 8'h00;
      r_done     <= 1'b0;
      r_pop_data <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_payload <= cmd_push ? cmd_data : r_payload;
          r_state   <= cmd_push ? PUSH_HI : POP_LO;
        end
        PUSH_HI: if (mem_ack) r_state <= PUSH_LO;
        PUSH_LO: if (mem_ack) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        POP_LO: if (mem_ack) begin
          r_lo    <= mem_rdata;
          r_state <= POP_HI;
        end
        POP_HI: if (mem_ack) begin
          r_pop_data <= {mem_rdata, r_lo};
          r_state    <= IDLE;
          r_done     <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: directed bench with an SP-unit model and a byte memory with programmable ack delay
module tb_stack_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_push = 1'b0;
  logic [15:0] cmd_data = 16'h0000;
  logic        cmd_ready;
  logic        cmd_done;
  logic [15:0] pop_data;
  logic [15:0] sp = 16'h0000;
  logic [2:0]  sp_sel;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  mem [0:65535];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        stray_ack = 1'b0;
  logic        sp_ld = 1'b0;
  logic [15:0] sp_ld_v = 16'h0000;
  logic        hist_clr = 1'b0;
  logic [15:0] sel_hist = 16'h0000;
  logic [47:0] wr_hist = 48'h0;
  logic [47:0] rd_hist = 48'h0;
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  stack_seq dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_push(cmd_push),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .cmd_done(cmd_done), .pop_data(pop_data),
    .sp(sp), .sp_sel(sp_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  always #5 clock = ~clock;
  assign mem_ack   = stray_ack || (mem_req && wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) begin
    sp <= sp_ld ? sp_ld_v : sp_sel == 3'd1 ? sp + 16'd1 : sp_sel == 3'd2 ? sp - 16'd1 : sp;
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    if (hist_clr) begin
      sel_hist <= 16'h0;
      wr_hist  <= 48'h0;
      rd_hist  <= 48'h0;
    end else if (!reset) begin
      if (sp_sel != 3'd0) sel_hist <= {sel_hist[11:0], 1'b0, sp_sel};
      if (mem_req && mem_ack && mem_we) wr_hist <= {wr_hist[23:0], mem_addr, mem_wdata};
      if (mem_req && mem_ack && !mem_we) rd_hist <= {rd_hist[23:0], mem_addr, mem_rdata};
    end
  end
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic load_sp(input logic [15:0] v);
    sp_ld = 1'b1;
    sp_ld_v = v;
    step();
    sp_ld = 1'b0;
  endtask
  task automatic run_cmd(input logic push, input logic [15:0] d, output int n);
    logic        have_prev;
    logic [15:0] p_addr;
    logic [7:0]  p_wdata;
    logic        p_we;
    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
    check("ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_push = push;
    cmd_data = d;
    #1;
    check("accept_sp_sel", sp_sel, push ? 3'd2 : 3'd0);
    n = 1;
    have_prev = 1'b0;
    step();
    cmd_valid = 1'b0;
    n = 2;
    while (!cmd_done && n < 60) begin
      if (mem_req && !mem_ack) check("wait_sp_sel", sp_sel, 0);
      if (have_prev) check("wait_stable", {mem_addr, mem_wdata, mem_we}, {p_addr, p_wdata, p_we});
      have_prev = mem_req && !mem_ack;
      p_addr = mem_addr;
      p_wdata = mem_wdata;
      p_we = mem_we;
      step();
      n++;
    end
    check("cmd_done_seen", cmd_done, 1);
  endtask
  initial begin
    step();
    step();
    check("rst_ready", cmd_ready, 1);
    check("rst_done", cmd_done, 0);
    check("rst_pop_data", pop_data, 16'h0000);
    check("rst_bus", {mem_req, mem_we, mem_addr, mem_wdata, sp_sel}, 0);
    reset = 1'b0;
    // push BEEF at SP=FFFE, zero-wait
    load_sp(16'hFFFE);
    run_cmd(1'b1, 16'hBEEF, cyc);
    check("push1_cycles", cyc, 4);
    check("push1_sel", sel_hist, 16'h0022);
    check("push1_writes", wr_hist, {24'hFFFDBE, 24'hFFFCEF});
    check("push1_sp", sp, 16'hFFFC);
    // pop it back
    run_cmd(1'b0, 16'h0000, cyc);
    check("pop1_cycles", cyc, 4);
    check("pop1_data", pop_data, 16'hBEEF);
    check("pop1_reads", rd_hist, {24'hFFFCEF, 24'hFFFDBE});
    check("pop1_sel", sel_hist, 16'h0011);
    check("pop1_sp", sp, 16'hFFFE);
    // three wait cycles per byte
    ack_delay = 3;
    run_cmd(1'b1, 16'h1234, cyc);
    check("push2_cycles", cyc, 10);
    check("push2_writes", wr_hist, {24'hFFFD12, 24'hFFFC34});
    check("push2_sel", sel_hist, 16'h0022);
    check("push2_sp", sp, 16'hFFFC);
    check("pop_data_held", pop_data, 16'hBEEF);
    // SP wrap-around
    ack_delay = 0;
    load_sp(16'h0001);
    run_cmd(1'b1, 16'h1234, cyc);
    check("wrap_cycles", cyc, 4);
    check("wrap_writes", wr_hist, {24'h000012, 24'hFFFF34});
    check("wrap_sp", sp, 16'hFFFF);
    // reset while in PUSH_LO after the high byte was acknowledged
    ack_delay = 2;
    load_sp(16'h0100);
    cmd_valid = 1'b1;
    cmd_push = 1'b1;
    cmd_data = 16'hABCD;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    check("rst_mid_state", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h00FE, 8'hCD});
    reset = 1'b1;
    step();
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_ready", cmd_ready, 1);
    check("rst_mid_sel", sp_sel, 0);
    check("rst_mid_done", cmd_done, 0);
    check("rst_mid_pop_data", pop_data, 16'h0000);
    reset = 1'b0;
    step();
    check("rst_mid_no_done", cmd_done, 0);
    check("rst_mid_partial_write", mem[16'h00FF], 8'hAB);
    check("rst_mid_sp", sp, 16'h00FE);
    // cmd_valid held through a pop; next command accepted only once IDLE
    ack_delay = 0;
    load_sp(16'hFFFC);
    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
    cmd_valid = 1'b1;
    cmd_push = 1'b0;
    step();
    cmd_push = 1'b1;
    cmd_data = 16'h5678;
    #1;
    check("busy_ready_c2", cmd_ready, 0);
    check("busy_sel_c2", sp_sel, 1);
    step();
    check("busy_ready_c3", cmd_ready, 0);
    step();
    check("held_done_c4", cmd_done, 1);
    check("held_pop_data", pop_data, 16'h1234);
    check("held_accept_sel", sp_sel, 2);
    check("held_sp", sp, 16'hFFFE);
    step();
    cmd_valid = 1'b0;
    cyc = 5;
    while (!cmd_done && cyc < 60) begin
      step();
      cyc++;
    end
    check("held_push_cycle", cyc, 7);
    check("held_writes", wr_hist, {24'hFFFD56, 24'hFFFC78});
    check("held_sel", sel_hist, 16'h1122);
    check("held_final_sp", sp, 16'hFFFC);
    // stray ack while idle
    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stray_idle", {cmd_ready, mem_req, sp_sel, cmd_done}, {1'b1, 1'b0, 3'd0, 1'b0});
      step();
    end
    stray_ack = 1'b0;
    check("stray_sel_hist", sel_hist, 16'h0000);
    check("stray_sp", sp, 16'hFFFC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Stack transaction sequencer that consumes the CPU's 16-bit stack pointer. It performs 16-bit PUSH and POP operations as two 8-bit memory transactions each.
- Drives the SP unit's select input: decrement before each push byte, increment after each pop byte.
- Drives the byte-wide memory request/acknowledge interface.
- Sits between the instruction decoder (commands for PUSH/POP/CALL/RET/RST) and the memory arbiter.

Parameters:
- None. SP select encodings and FSM state encodings come from the shared package.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request from decoder
- cmd_push  in  1  1 = push, 0 = pop; sampled on accept
- cmd_data  in  16  push payload; sampled on accept
- cmd_ready  out  1  high only in IDLE
- cmd_done  out  1  one-cycle pulse, one cycle after final byte acknowledged
- pop_data  out  16  popped word; valid from cmd_done, held until next pop completes
- sp  in  16  current registered SP value
- sp_sel  out  3  SP select: 0 hold, 1 incr, 2 decr; other values never driven
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; meaningful only with mem_req
- mem_addr  out  16  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte; valid in the mem_ack cycle
- mem_ack  in  1  transaction complete; any number of cycles after req (including the same cycle)

Behaviour:
- Reset values:
  - state IDLE, cmd_ready=1, cmd_done=0, pop_data=0000.
  - mem_req=0, mem_we=0, mem_addr=0000, mem_wdata=00, sp_sel=0.
  - Internal payload and byte capture registers cleared.
- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI.
- IDLE:
  - Accept when cmd_valid && cmd_ready.
  - Push accept: latch cmd_data, sp_sel=2 this cycle, go PUSH_HI.
  - Pop accept: sp_sel=0, go POP_LO.
- PUSH_HI:
  - mem_req=1, mem_we=1, mem_addr=sp, mem_wdata=payload[15:8].
  - On mem_ack: sp_sel=2, go PUSH_LO.
- PUSH_LO:
  - mem_req=1, mem_we=1, mem_addr=sp, mem_wdata=payload[7:0].
  - On mem_ack: go IDLE, cmd_done=1 next cycle.
- POP_LO:
  - mem_req=1, mem_we=0, mem_addr=sp.
  - On mem_ack: capture mem_rdata into low byte, sp_sel=1, go POP_HI.
- POP_HI:
  - mem_req=1, mem_we=0, mem_addr=sp.
  - On mem_ack: capture high byte, sp_sel=1, go IDLE.
  - Next cycle: pop_data={hi,lo} and cmd_done=1.
- Timing dependency: the SP unit registers sp_sel on the edge, so the updated sp is visible the cycle after sp_sel≠0. Every state is therefore entered with sp already adjusted.
- Wait states:
  - While mem_req=1 and mem_ack=0: mem_addr, mem_wdata and mem_we are held stable, and sp_sel=0.
  - Outside the cycles listed above, sp_sel=0.
- Latency:
  - Zero-wait memory: push and pop each take 3 cycles from accept to final ack; cmd_done arrives in cycle 4.
  - Each wait cycle adds 1.
- Wrap-around: SP arithmetic is modulo 2^16 in the SP unit. A push at SP=0001 writes 0000 then FFFF. No flag is raised.
- cmd_valid while busy: ignored and not queued; the decoder holds it until cmd_ready.
- mem_ack with mem_req=0: ignored.
- Reset mid-operation:
  - Returns to IDLE next edge, with mem_req=0 and sp_sel=0.
  - No cmd_done is issued; pop_data is cleared.
  - Any partial memory write stands.
- cmd_done and a new accept may occur in the same cycle, since state is IDLE.

Decomposition:
- Shared package: SP select constants (SP_SEL_HOLD=0, SP_SEL_INCR=1, SP_SEL_DECR=2, SP_SEL_TEMP=3, SP_SEL_REL=4, shared with the SP unit) and stack_seq state encoding.
- No sub-module: one FSM with registered outputs for cmd_done and pop_data, and combinational bus/sp_sel outputs decoded from state.

Test Plan:
- Push BEEF, SP model=FFFE, zero-wait ack → writes FFFD←BE, then FFFC←EF; sp_sel sequence 2,2; final SP=FFFC; cmd_done in cycle 4.
- Pop directly after → reads FFFC (EF), FFFD (BE); sp_sel 1,1; pop_data=BEEF with cmd_done; SP=FFFE.
- Push 1234 with ack delayed 3 cycles per byte → addr, wdata and we stable during waits; sp_sel=0 while waiting; cmd_done at cycle 10.
- SP=0001, push 1234 → writes 0000←12, FFFF←34; final SP=FFFF; no stall.
- Reset asserted in PUSH_LO after high-byte ack → mem_req=0 and cmd_ready=1 next cycle; no cmd_done; pop_data=0000.
- cmd_valid held during pop, plus a stray mem_ack in IDLE → second command accepted only in IDLE; stray ack causes no state change or sp_sel activity.
